// File: rtl/spi_target_pkg.sv
// -----------------------------------------------------------------------------
// xosera_pkg
// Constants and types shared by the SPI target and its synchronizer.
//   SPI_BITS_PER_BYTE : bits per SPI transfer unit
//   SPI_MIN_SCK_PHASE : minimum SCK high/low phase in system clocks
//   SPI_CNT_W         : width of the per-byte bit counter
//   spi_state_t       : transaction state (idle, post-reset lockout, active)
// -----------------------------------------------------------------------------
package xosera_pkg;

    localparam int unsigned SPI_BITS_PER_BYTE = 8;
    localparam int unsigned SPI_MIN_SCK_PHASE = 4;
    localparam int unsigned SPI_CNT_W         = $clog2(SPI_BITS_PER_BYTE);

    typedef enum logic [1:0] {
        SPI_IDLE    = 2'd0,
        SPI_LOCKOUT = 2'd1,
        SPI_ACTIVE  = 2'd2
    } spi_state_t;

    typedef logic [SPI_BITS_PER_BYTE-1:0] spi_byte_t;

endpackage

// File: rtl/spi_target_sync_bit.sv
// -----------------------------------------------------------------------------
// sync_bit
// N-flop synchronizer for one asynchronous input, followed by one history
// register used for edge detection. Level and edge outputs are aligned:
// all three reflect the same synchronized sample, STAGES+1 clocks after the
// pin changed.
//   clk     : system clock
//   reset   : synchronous active-high reset (clears the edge strobes only)
//   d_i     : asynchronous input
//   level_o : synchronized level
//   rise_o  : one-cycle strobe, synchronized rising edge
//   fall_o  : one-cycle strobe, synchronized falling edge
// -----------------------------------------------------------------------------
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;
    logic              rise_q;
    logic              rise_d;
    logic              fall_q;
    logic              fall_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
        prev_d = sync_q[STAGES-1];
        rise_d = sync_q[STAGES-1] & ~prev_q;
        fall_d = ~sync_q[STAGES-1] & prev_q;
    end

    // The chain keeps tracking the pin through reset so the level is already
    // valid when reset releases; this is what lets the parent detect a CS
    // that was held low across reset.
    always_ff @(posedge clk) begin
        sync_q <= sync_d;
        prev_q <= prev_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level_o = prev_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/spi_target.sv
// -----------------------------------------------------------------------------
// spi_target
// SPI mode-0 target. SCK, COPI and CS are oversampled by clk; received bytes
// are presented as a strobed byte stream and reply bytes are shifted out on
// CIPO, MSB first.
//   clk, reset   : system clock, synchronous active-high reset
//   spi_sck_i    : SPI clock (asynchronous)
//   spi_copi_i   : controller-out data (asynchronous)
//   spi_cs_i     : chip select, active low (asynchronous)
//   spi_cipo_o   : target-out data, 0 while no transaction is open
//   rx_byte_o    : last complete received byte
//   rx_valid_o   : one-cycle strobe, rx_byte_o is new
//   rx_first_o   : with rx_valid_o, byte is the first of the CS frame
//   tx_byte_i    : next reply byte, sampled only when tx_load_o is high
//   tx_load_o    : one-cycle strobe, tx_byte_i sampled this cycle
//   cs_active_o  : transaction open
// -----------------------------------------------------------------------------
module spi_target #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_sck_i,
    input  logic       spi_copi_i,
    input  logic       spi_cs_i,
    output logic       spi_cipo_o,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o,
    output logic       rx_first_o,
    input  logic [7:0] tx_byte_i,
    output logic       tx_load_o,
    output logic       cs_active_o
);

    import xosera_pkg::*;

    localparam logic [SPI_CNT_W-1:0] LAST_BIT = SPI_CNT_W'(SPI_BITS_PER_BYTE - 1);

    // -------------------------------------------------------------------------
    // Input synchronizers
    // -------------------------------------------------------------------------
    logic sck_rise;
    logic sck_fall;
    logic sck_level_unused;
    logic cs_level;
    logic cs_rise;
    logic cs_fall;
    logic copi_level;
    logic copi_rise_unused;
    logic copi_fall_unused;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk     (clk),
        .reset   (reset),
        .d_i     (spi_sck_i),
        .level_o (sck_level_unused),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    sync_bit #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk     (clk),
        .reset   (reset),
        .d_i     (spi_cs_i),
        .level_o (cs_level),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    // COPI goes through the same depth so its level lines up with sck_rise.
    sync_bit #(.STAGES(SYNC_STAGES)) u_copi_sync (
        .clk     (clk),
        .reset   (reset),
        .d_i     (spi_copi_i),
        .level_o (copi_level),
        .rise_o  (copi_rise_unused),
        .fall_o  (copi_fall_unused)
    );

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    spi_state_t                   state_q,      state_d;
    logic [SPI_CNT_W-1:0]         bit_cnt_q,    bit_cnt_d;
    // Seven bits suffice: the eighth comes straight from copi_level.
    logic [SPI_BITS_PER_BYTE-2:0] rx_shift_q,   rx_shift_d;
    spi_byte_t                    tx_shift_q,   tx_shift_d;
    logic                         armed_q,      armed_d;
    logic                         byte_done_q,  byte_done_d;
    spi_byte_t                    rx_byte_q,    rx_byte_d;
    logic                         rx_valid_q,   rx_valid_d;
    logic                         rx_first_q,   rx_first_d;
    logic                         cs_active_q,  cs_active_d;
    logic                         cipo_q,       cipo_d;
    logic                         tx_load;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        armed_d     = armed_q;
        byte_done_d = byte_done_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        rx_first_d  = 1'b0;
        tx_load     = 1'b0;

        unique case (state_q)
            // CS was low when reset released: wait for it to go high so a
            // half-received frame is never picked up mid-stream.
            SPI_LOCKOUT: begin
                if (cs_level) begin
                    state_d = SPI_IDLE;
                end
            end

            SPI_IDLE: begin
                if (cs_fall) begin
                    state_d     = SPI_ACTIVE;
                    bit_cnt_d   = '0;
                    tx_shift_d  = tx_byte_i;
                    tx_load     = 1'b1;
                    armed_d     = 1'b1;
                    byte_done_d = 1'b0;
                end
            end

            SPI_ACTIVE: begin
                if (sck_rise) begin
                    rx_shift_d = {rx_shift_q[SPI_BITS_PER_BYTE-3:0], copi_level};
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_byte_d   = {rx_shift_q, copi_level};
                        rx_valid_d  = 1'b1;
                        rx_first_d  = armed_q;
                        armed_d     = 1'b0;
                        byte_done_d = 1'b1;
                    end
                end else if (sck_fall) begin
                    if ((bit_cnt_q == '0) && byte_done_q) begin
                        tx_shift_d = tx_byte_i;
                        tx_load    = 1'b1;
                    end else begin
                        tx_shift_d = {tx_shift_q[SPI_BITS_PER_BYTE-2:0], 1'b0};
                    end
                end
                // Evaluated after the SCK edge so a byte completing in the
                // same cycle as CS release is still delivered.
                if (cs_rise) begin
                    state_d   = SPI_IDLE;
                    bit_cnt_d = '0;
                end
            end

            default: begin
                state_d = SPI_LOCKOUT;
            end
        endcase

        cs_active_d = (state_d == SPI_ACTIVE);
        cipo_d      = cs_active_d & tx_shift_d[SPI_BITS_PER_BYTE-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SPI_LOCKOUT;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            armed_q     <= 1'b0;
            byte_done_q <= 1'b0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_first_q  <= 1'b0;
            cs_active_q <= 1'b0;
            cipo_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            armed_q     <= armed_d;
            byte_done_q <= byte_done_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            rx_first_q  <= rx_first_d;
            cs_active_q <= cs_active_d;
            cipo_q      <= cipo_d;
        end
    end

    assign spi_cipo_o  = cipo_q;
    assign rx_byte_o   = rx_byte_q;
    assign rx_valid_o  = rx_valid_q;
    assign rx_first_o  = rx_first_q;
    assign cs_active_o = cs_active_q;
    // Combinational so the strobe marks the very cycle tx_byte_i is captured;
    // it only depends on registered edge strobes and state.
    assign tx_load_o   = tx_load;

endmodule

// File: tb/tb_spi_target.sv
// -----------------------------------------------------------------------------
// tb_spi_target
// Directed bench for spi_target: a bit-banged SPI controller drives the pins,
// expected received bytes are queued as they are sent and checked when the
// DUT strobes rx_valid_o.
// -----------------------------------------------------------------------------
module tb_spi_target;

    import xosera_pkg::*;

    localparam int unsigned HALF     = SPI_MIN_SCK_PHASE;
    localparam int unsigned CS_SETUP = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       sck;
    logic       copi;
    logic       cs;
    logic       cipo;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_first;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic       cs_active;

    always #5 clk = ~clk;

    spi_target #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .spi_sck_i   (sck),
        .spi_copi_i  (copi),
        .spi_cs_i    (cs),
        .spi_cipo_o  (cipo),
        .rx_byte_o   (rx_byte),
        .rx_valid_o  (rx_valid),
        .rx_first_o  (rx_first),
        .tx_byte_i   (tx_byte),
        .tx_load_o   (tx_load),
        .cs_active_o (cs_active)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       first;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert    = 0;
    int   n_fail      = 0;
    int   load_cnt    = 0;
    int   cyc         = 0;
    int   last_strobe = -1;
    bit   spacing_on  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard side: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (tx_load === 1'b1) load_cnt++;
        if (rx_valid === 1'b1) begin
            check("strobe_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rx_byte", rx_byte, e.data);
                check("rx_first", rx_first, e.first);
            end
            if (spacing_on) begin
                if (last_strobe >= 0) check("strobe_spacing", cyc - last_strobe, 64);
                last_strobe = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, output logic c);
        copi = b;
        tick(HALF);
        c   = cipo;
        sck = 1'b1;
        tick(HALF);
        sck = 1'b0;
    endtask

    // Full byte; next_tx is presented right after the 8th rising edge so it
    // is in place before the falling-edge load point.
    task automatic spi_xfer(input logic [7:0] tx, input logic [7:0] next_tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            copi = tx[i];
            tick(HALF);
            rx[i] = cipo;
            sck   = 1'b1;
            if (i == 0) tx_byte = next_tx;
            tick(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic cs_open();
        cs = 1'b0;
        tick(CS_SETUP);
    endtask

    task automatic cs_close();
        tick(2);
        cs = 1'b1;
        tick(8);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick(1);
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] r;
        logic       c;
        logic [7:0] d;
        logic [7:0] nx;
        logic [7:0] prev_tx;
        logic       seen;
        logic       act_before;

        reset   = 1'b1;
        sck     = 1'b0;
        copi    = 1'b0;
        cs      = 1'b1;
        tx_byte = 8'h00;
        tick(8);
        reset = 1'b0;
        tick(1);

        // Reset values
        check("rst_cipo", cipo, 0);
        check("rst_rx_byte", rx_byte, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_first", rx_first, 0);
        check("rst_tx_load", tx_load, 0);
        check("rst_cs_active", cs_active, 0);
        tick(4);

        // Single byte loopback
        load_cnt = 0;
        tx_byte  = 8'h3C;
        exp_q.push_back('{data: 8'hA5, first: 1'b1});
        cs_open();
        check("open_cs_active", cs_active, 1);
        spi_xfer(8'hA5, 8'h00, r);
        check("loop_cipo", r, 8'h3C);
        cs_close();
        drain("loop_drain");
        check("loop_loads", load_cnt, 2);
        check("idle_cs_active", cs_active, 0);

        // Three bytes in one frame
        load_cnt = 0;
        tx_byte  = 8'h11;
        exp_q.push_back('{data: 8'h01, first: 1'b1});
        exp_q.push_back('{data: 8'h02, first: 1'b0});
        exp_q.push_back('{data: 8'h03, first: 1'b0});
        cs_open();
        spi_xfer(8'h01, 8'h22, r);
        check("multi_cipo0", r, 8'h11);
        spi_xfer(8'h02, 8'h33, r);
        check("multi_cipo1", r, 8'h22);
        spi_xfer(8'h03, 8'h44, r);
        check("multi_cipo2", r, 8'h33);
        cs_close();
        drain("multi_drain");
        check("multi_loads", load_cnt, 4);

        // Abort after five bits, then a fresh frame
        cs_open();
        for (int i = 0; i < 5; i++) spi_bit(1'b1, c);
        cs_close();
        tick(8);
        check("abort_rx_byte", rx_byte, 8'h03);
        exp_q.push_back('{data: 8'hFF, first: 1'b1});
        tx_byte = 8'h00;
        cs_open();
        spi_xfer(8'hFF, 8'h00, r);
        cs_close();
        drain("abort_drain");

        // Reset mid-frame with CS held low across it
        cs_open();
        for (int i = 0; i < 3; i++) spi_bit(1'b0, c);
        reset = 1'b1;
        tick(2);
        check("mrst_cs_active", cs_active, 0);
        check("mrst_rx_byte", rx_byte, 8'h00);
        check("mrst_cipo", cipo, 0);
        tick(6);
        reset = 1'b0;
        tick(4);
        tx_byte = 8'hE7;
        spi_xfer(8'h5A, 8'hE7, r);
        check("lock_cipo", r, 8'h00);
        check("lock_cs_active", cs_active, 0);
        check("lock_rx_byte", rx_byte, 8'h00);
        check("lock_rx_valid", rx_valid, 0);
        cs = 1'b1;
        tick(8);
        exp_q.push_back('{data: 8'h96, first: 1'b1});
        tx_byte = 8'hC3;
        cs_open();
        spi_xfer(8'h96, 8'h00, r);
        check("relock_cipo", r, 8'hC3);
        cs_close();
        drain("relock_drain");

        // Sixteen back-to-back bytes at SCK = clk/8
        spacing_on  = 1'b1;
        last_strobe = -1;
        prev_tx     = 8'($urandom);
        tx_byte     = prev_tx;
        cs_open();
        for (int i = 0; i < 16; i++) begin
            d  = 8'($urandom);
            nx = 8'($urandom);
            exp_q.push_back('{data: d, first: (i == 0)});
            spi_xfer(d, nx, r);
            check("rate_cipo", r, prev_tx);
            prev_tx = nx;
        end
        cs_close();
        drain("rate_drain");
        spacing_on = 1'b0;

        // 8th SCK rise and CS rise on the same clock
        exp_q.push_back('{data: 8'hC7, first: 1'b1});
        tx_byte = 8'h00;
        d       = 8'hC7;
        cs_open();
        for (int i = 7; i >= 1; i--) spi_bit(d[i], c);
        copi = d[0];
        tick(HALF);
        sck = 1'b1;
        cs  = 1'b1;
        seen       = 1'b0;
        act_before = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            act_before = cs_active;
            tick(1);
            if (rx_valid === 1'b1) seen = 1'b1;
        end
        check("coinc_strobe", seen, 1);
        check("coinc_active_before", act_before, 1);
        check("coinc_active_after", cs_active, 0);
        tick(HALF);
        sck = 1'b0;
        tick(10);
        drain("coinc_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_target.md
# spi_target

SPI mode-0 target that turns the FTDI SPI pins (SCK, COPI, CS active-low) into a byte stream in the video clock domain and shifts reply bytes out on CIPO. It sits between the board top-level pin wiring and the register/command logic inside `xosera_main`. SCK and CS are oversampled by the system clock; the block contains no second clock domain.

## Interface
**Parameters**
- `SYNC_STAGES`, 2: flip-flop depth of each input synchronizer (≥2).

**Ports**
- `clk`  in  1: system (pixel) clock; the only clock.
- `reset`  in  1: synchronous, active-high reset.
- `spi_sck_i`  in  1: SPI clock, asynchronous.
- `spi_copi_i`  in  1: controller-out data, asynchronous.
- `spi_cs_i`  in  1: chip select, active low, asynchronous.
- `spi_cipo_o`  out  1: target-out data.
- `rx_byte_o`  out  8: last complete received byte, MSB first on wire.
- `rx_valid_o`  out  1: one-cycle strobe; `rx_byte_o` is new.
- `rx_first_o`  out  1: qualifies `rx_valid_o`; byte is first since CS asserted.
- `tx_byte_i`  in  8: next reply byte; sampled at load points only.
- `tx_load_o`  out  1: one-cycle strobe, the cycle `tx_byte_i` was sampled.
- `cs_active_o`  out  1: synchronized, qualified CS (1 = transaction open).

## Operation
- SCK, COPI and CS each pass through `SYNC_STAGES` flops. One extra register per line gives edge detection. COPI is delayed identically so it stays aligned with SCK.
- Transaction open: synchronized CS falls while not in post-reset lockout. Then:
  - `bit_cnt` clears to 0.
  - `tx_shift` loads `tx_byte_i`; `tx_load_o` pulses.
  - `rx_first_o` flag is armed.
- SCK rising edge (CS active):
  - `rx_shift <= {rx_shift[6:0], copi}`; `bit_cnt` increments mod 8.
  - On the 8th edge (`bit_cnt` 7→0), next cycle: `rx_byte_o` updates, `rx_valid_o` = 1, `rx_first_o` = armed flag; flag then clears.
- SCK falling edge (CS active):
  - If `bit_cnt` == 0 and at least one byte is complete: load `tx_shift` from `tx_byte_i` and pulse `tx_load_o`.
  - Otherwise: shift `tx_shift` left.
- `spi_cipo_o` = `tx_shift[7]` while CS active, else 0.
- CS rising edge mid-byte: partial byte discarded, no `rx_valid_o`, `bit_cnt` cleared.
- SCK rising edge and CS rise seen in the same cycle: the edge is processed first, so a byte completed on that edge is still delivered.
- Post-reset lockout: if synchronized CS is low when reset releases, the block stays idle until CS goes high, then waits for a fresh falling edge.

## Timing
- Reset values: `spi_cipo_o` 0, `rx_byte_o` 0x00, `rx_valid_o` 0, `rx_first_o` 0, `tx_load_o` 0, `cs_active_o` 0.
- Latency, pin edge to internal action: `SYNC_STAGES`+1 clk.
- Latency, 8th SCK rising edge at pin to `rx_valid_o`: `SYNC_STAGES`+2 clk (4 at default).
- CS fall at pin to first bit valid on CIPO: `SYNC_STAGES`+2 clk. The controller must allow ≥ this CS-to-first-SCK setup.
- SCK high and low phases must each be ≥4 clk, so max SCK = clk/8.
- `rx_valid_o` minimum spacing: 8 SCK periods. The consumer has no back-pressure; it must accept every strobe.
- `tx_byte_i` must be stable from the previous `rx_valid_o` to the next falling-edge load point (≥ half an SCK period).

## Structure
- Shared package `xosera_pkg`: `SPI_BITS_PER_BYTE = 8` and the minimum SCK-phase constant (4).
- Sub-module `sync_bit`: parameterised N-flop synchronizer with registered edge outputs. One instance each for SCK, CS and COPI.
- The rest is flat: lockout FSM (IDLE, LOCKOUT, ACTIVE), bit counter, two shift registers.

## Test plan
- Byte loopback: CS low, controller sends 0xA5, `tx_byte_i` = 0x3C → `rx_byte_o` = 0xA5, `rx_valid_o` pulses once, `rx_first_o` = 1; CIPO bits 0,0,1,1,1,1,0,0.
- Multi-byte: send 0x01,0x02,0x03 in one CS frame, host sets `tx_byte_i` after each strobe → three strobes, `rx_first_o` only on 0x01; second and third replies equal the values presented at load.
- Abort: CS rises after 5 SCK edges, then a new frame sends 0xFF → no strobe for the partial byte; next strobe carries 0xFF with `rx_first_o` = 1.
- Reset mid-frame: assert `reset` with CS low after 3 bits, release with CS still low → no strobes until CS goes high then low again. All outputs are at reset values during lockout.
- Max rate: SCK = clk/8 for 16 bytes of pseudo-random data → all 16 received in order, strobe spacing = 64 clk.
- Coincident edges: 8th SCK rise and CS rise in the same synchronized cycle → the byte is delivered and `cs_active_o` falls one cycle later.
